// File: rtl/zion_turtle_lsu_pkg.sv
// -----------------------------------------------------------------------------
// zion_turtle_lsu_pkg
// Shared types and helpers for the Turtle LSU memory responder.
//   - lsu_width_e : access width encoding from the decode stage
//   - lsu_state_e : responder FSM states
//   - lsu_exc_e   : exception cause encoding reported on oExcCause
//   - byte-enable constants and helpers for alignment and lane enables
// -----------------------------------------------------------------------------
package zion_turtle_lsu_pkg;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'b00,
        WIDTH_HALF = 2'b01,
        WIDTH_WORD = 2'b10,
        WIDTH_RSVD = 2'b11
    } lsu_width_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_REQ    = 2'b01,
        ST_RSP    = 2'b10,
        ST_RETIRE = 2'b11
    } lsu_state_e;

    typedef enum logic [1:0] {
        EXC_NONE       = 2'b00,
        EXC_MISALIGN   = 2'b01,
        EXC_RSVD_WIDTH = 2'b10,
        EXC_TIMEOUT    = 2'b11
    } lsu_exc_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Byte enables for an access of width w at byte offset a.
    function automatic logic [3:0] lsu_byte_en(input lsu_width_e w, input logic [1:0] a);
        logic [3:0] be;
        case (w)
            WIDTH_BYTE: be = BE_BYTE << a;
            WIDTH_HALF: be = BE_HALF << {a[1], 1'b0};
            WIDTH_WORD: be = BE_WORD;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

    // Exception cause for an access; reserved width takes priority over alignment.
    function automatic lsu_exc_e lsu_check(input lsu_width_e w, input logic [1:0] a);
        lsu_exc_e c;
        case (w)
            WIDTH_BYTE: c = EXC_NONE;
            WIDTH_HALF: c = (a[0] != 1'b0) ? EXC_MISALIGN : EXC_NONE;
            WIDTH_WORD: c = (a != 2'b00) ? EXC_MISALIGN : EXC_NONE;
            default:    c = EXC_RSVD_WIDTH;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/zion_turtle_lsu_load_align.sv
// -----------------------------------------------------------------------------
// zion_turtle_lsu_load_align
// Combinational load-data lane select and sign/zero extension.
// Ports:
//   rdat        in  32  raw read data from the bus
//   addr_lo     in  2   byte offset of the access
//   width       in  2   access width (lsu_width_e)
//   unsigned_flg in 1   zero-extend instead of sign-extend (byte/half only)
//   dat         out 32  aligned, extended write-back data
// -----------------------------------------------------------------------------
module zion_turtle_lsu_load_align
    import zion_turtle_lsu_pkg::*;
(
    input  logic [31:0] rdat,
    input  logic [1:0]  addr_lo,
    input  lsu_width_e  width,
    input  logic        unsigned_flg,
    output logic [31:0] dat
);

    logic [31:0] byte_sh_s;
    logic [31:0] half_sh_s;

    // Select the addressed lane and extend it to 32 bits.
    always_comb begin
        byte_sh_s = rdat >> {addr_lo, 3'b000};
        half_sh_s = rdat >> {addr_lo[1], 4'b0000};
        case (width)
            WIDTH_BYTE: begin
                if (unsigned_flg) begin
                    dat = {24'h000000, byte_sh_s[7:0]};
                end else begin
                    dat = {{24{byte_sh_s[7]}}, byte_sh_s[7:0]};
                end
            end
            WIDTH_HALF: begin
                if (unsigned_flg) begin
                    dat = {16'h0000, half_sh_s[15:0]};
                end else begin
                    dat = {{16{half_sh_s[15]}}, half_sh_s[15:0]};
                end
            end
            default: dat = rdat;
        endcase
    end

endmodule

// File: rtl/zion_turtle_lsu_mem_responder.sv
// -----------------------------------------------------------------------------
// zion_turtle_lsu_mem_responder
// Executes one outstanding LSU data-memory transaction on a req/gnt/rvld bus,
// returns aligned/extended load data for write-back and reports exceptions.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   iReqVld/oReqRdy            op handshake (accept = iReqVld & oReqRdy & iMemEn)
//   iMemEn,iLoad,iStore,iUnsignedFlg,iMemWidth,iStoreDat,iAddr,iRd  op fields
//   oMemReq,oMemWr,oMemAddr,oMemWdat,oMemBe / iMemGnt,iMemRvld,iMemRdat  bus
//   oWbVld,oWbRd,oWbDat        load write-back pulse
//   oDone                      op retired pulse
//   oExcVld,oExcCause,oExcAddr exception pulse, cause and faulting address
//   oBusy                      FSM not idle
// -----------------------------------------------------------------------------
module zion_turtle_lsu_mem_responder
    import zion_turtle_lsu_pkg::*;
#(
    parameter logic [7:0]  TIMEOUT_CYCLES   = 8'd255,
    parameter logic [31:0] RESET_PC_INVALID = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iReqVld,
    output logic        oReqRdy,
    input  logic        iMemEn,
    input  logic        iLoad,
    input  logic        iStore,
    input  logic        iUnsignedFlg,
    input  logic [1:0]  iMemWidth,
    input  logic [31:0] iStoreDat,
    input  logic [31:0] iAddr,
    input  logic [4:0]  iRd,
    output logic        oMemReq,
    output logic        oMemWr,
    output logic [31:0] oMemAddr,
    output logic [31:0] oMemWdat,
    output logic [3:0]  oMemBe,
    input  logic        iMemGnt,
    input  logic        iMemRvld,
    input  logic [31:0] iMemRdat,
    output logic        oWbVld,
    output logic [4:0]  oWbRd,
    output logic [31:0] oWbDat,
    output logic        oDone,
    output logic        oExcVld,
    output logic [1:0]  oExcCause,
    output logic [31:0] oExcAddr,
    output logic        oBusy
);

    lsu_state_e  state_q;
    logic        wr_q;
    lsu_width_e  width_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [4:0]  rd_q;
    logic [7:0]  cnt_q;

    logic        mem_req_q, mem_wr_q;
    logic [31:0] mem_addr_q, mem_wdat_q;
    logic [3:0]  mem_be_q;
    logic        wb_vld_q, done_q, exc_vld_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_dat_q, exc_addr_q;
    lsu_exc_e    exc_cause_q;

    logic        accept_s;
    logic        op_s;
    lsu_width_e  width_s;
    lsu_exc_e    chk_cause_s;
    logic [3:0]  be_s;
    logic [31:0] wdat_s;
    logic [7:0]  cnt_inc_s;
    logic        timeout_s;
    logic [31:0] ld_dat_s;

    // Decode-time derived values: acceptance, checks, lane enables, store data.
    always_comb begin
        width_s     = lsu_width_e'(iMemWidth);
        op_s        = iLoad | iStore;
        accept_s    = iReqVld & (state_q == ST_IDLE) & iMemEn;
        chk_cause_s = lsu_check(width_s, iAddr[1:0]);
        be_s        = lsu_byte_en(width_s, iAddr[1:0]);
        case (width_s)
            WIDTH_BYTE: wdat_s = {4{iStoreDat[7:0]}};
            WIDTH_HALF: wdat_s = {2{iStoreDat[15:0]}};
            default:    wdat_s = iStoreDat;
        endcase
        cnt_inc_s = cnt_q + 8'd1;
        // A zero limit disables the timeout altogether.
        if (TIMEOUT_CYCLES != 8'd0) begin
            timeout_s = (cnt_inc_s == TIMEOUT_CYCLES);
        end else begin
            timeout_s = 1'b0;
        end
    end

    zion_turtle_lsu_load_align u_load_align (
        .rdat         (iMemRdat),
        .addr_lo      (addr_q[1:0]),
        .width        (width_q),
        .unsigned_flg (unsigned_q),
        .dat          (ld_dat_s)
    );

    // Responder FSM with all bus, write-back and exception outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            width_q     <= WIDTH_BYTE;
            unsigned_q  <= 1'b0;
            addr_q      <= 32'h0000_0000;
            rd_q        <= 5'd0;
            cnt_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdat_q  <= 32'h0000_0000;
            mem_be_q    <= 4'b0000;
            wb_vld_q    <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_dat_q    <= 32'h0000_0000;
            done_q      <= 1'b0;
            exc_vld_q   <= 1'b0;
            exc_cause_q <= EXC_NONE;
            exc_addr_q  <= RESET_PC_INVALID;
        end else begin
            wb_vld_q  <= 1'b0;
            done_q    <= 1'b0;
            exc_vld_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_s && op_s) begin
                        // Load and store both set is handled as a store.
                        wr_q       <= iStore;
                        width_q    <= width_s;
                        unsigned_q <= iUnsignedFlg;
                        addr_q     <= iAddr;
                        rd_q       <= iRd;
                        if (chk_cause_s != EXC_NONE) begin
                            state_q     <= ST_RETIRE;
                            done_q      <= 1'b1;
                            exc_vld_q   <= 1'b1;
                            exc_cause_q <= chk_cause_s;
                            exc_addr_q  <= iAddr;
                        end else begin
                            state_q    <= ST_REQ;
                            cnt_q      <= 8'd0;
                            mem_req_q  <= 1'b1;
                            mem_wr_q   <= iStore;
                            mem_addr_q <= {iAddr[31:2], 2'b00};
                            mem_be_q   <= be_s;
                            mem_wdat_q <= wdat_s;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (iMemGnt) begin
                        mem_req_q <= 1'b0;
                        if (wr_q) begin
                            state_q <= ST_RETIRE;
                            done_q  <= 1'b1;
                        end else if (iMemRvld) begin
                            // Read data returned together with the grant.
                            state_q  <= ST_RETIRE;
                            done_q   <= 1'b1;
                            wb_vld_q <= (rd_q != 5'd0);
                            wb_rd_q  <= rd_q;
                            wb_dat_q <= ld_dat_s;
                        end else begin
                            state_q <= ST_RSP;
                            cnt_q   <= 8'd0;
                        end
                    end else if (timeout_s) begin
                        mem_req_q   <= 1'b0;
                        state_q     <= ST_RETIRE;
                        done_q      <= 1'b1;
                        exc_vld_q   <= 1'b1;
                        exc_cause_q <= EXC_TIMEOUT;
                        exc_addr_q  <= addr_q;
                    end else begin
                        cnt_q <= cnt_inc_s;
                    end
                end
                ST_RSP: begin
                    if (iMemRvld) begin
                        state_q  <= ST_RETIRE;
                        done_q   <= 1'b1;
                        wb_vld_q <= (rd_q != 5'd0);
                        wb_rd_q  <= rd_q;
                        wb_dat_q <= ld_dat_s;
                    end else if (timeout_s) begin
                        state_q     <= ST_RETIRE;
                        done_q      <= 1'b1;
                        exc_vld_q   <= 1'b1;
                        exc_cause_q <= EXC_TIMEOUT;
                        exc_addr_q  <= addr_q;
                    end else begin
                        cnt_q <= cnt_inc_s;
                    end
                end
                ST_RETIRE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign oReqRdy   = (state_q == ST_IDLE);
    assign oBusy     = (state_q != ST_IDLE);
    assign oMemReq   = mem_req_q;
    assign oMemWr    = mem_wr_q;
    assign oMemAddr  = mem_addr_q;
    assign oMemWdat  = mem_wdat_q;
    assign oMemBe    = mem_be_q;
    assign oWbVld    = wb_vld_q;
    assign oWbRd     = wb_rd_q;
    assign oWbDat    = wb_dat_q;
    assign oDone     = done_q;
    assign oExcVld   = exc_vld_q;
    assign oExcCause = exc_cause_q;
    assign oExcAddr  = exc_addr_q;

endmodule

// File: tb/tb_zion_turtle_lsu_mem_responder.sv
module tb_zion_turtle_lsu_mem_responder;

    localparam logic [31:0] RST_PC = 32'hBAD0_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iReqVld, oReqRdy, iMemEn, iLoad, iStore, iUnsignedFlg;
    logic [1:0]  iMemWidth;
    logic [31:0] iStoreDat, iAddr;
    logic [4:0]  iRd;
    logic        oMemReq, oMemWr;
    logic [31:0] oMemAddr, oMemWdat;
    logic [3:0]  oMemBe;
    logic        iMemGnt, iMemRvld;
    logic [31:0] iMemRdat;
    logic        oWbVld;
    logic [4:0]  oWbRd;
    logic [31:0] oWbDat;
    logic        oDone, oExcVld;
    logic [1:0]  oExcCause;
    logic [31:0] oExcAddr;
    logic        oBusy;

    int chk_cnt  = 0;
    int fail_cnt = 0;

    zion_turtle_lsu_mem_responder #(
        .TIMEOUT_CYCLES   (8'd4),
        .RESET_PC_INVALID (RST_PC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .iReqVld(iReqVld), .oReqRdy(oReqRdy),
        .iMemEn(iMemEn), .iLoad(iLoad), .iStore(iStore), .iUnsignedFlg(iUnsignedFlg),
        .iMemWidth(iMemWidth), .iStoreDat(iStoreDat), .iAddr(iAddr), .iRd(iRd),
        .oMemReq(oMemReq), .oMemWr(oMemWr), .oMemAddr(oMemAddr), .oMemWdat(oMemWdat),
        .oMemBe(oMemBe), .iMemGnt(iMemGnt), .iMemRvld(iMemRvld), .iMemRdat(iMemRdat),
        .oWbVld(oWbVld), .oWbRd(oWbRd), .oWbDat(oWbDat), .oDone(oDone),
        .oExcVld(oExcVld), .oExcCause(oExcCause), .oExcAddr(oExcAddr), .oBusy(oBusy)
    );

    always #5 clk = ~clk;

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single cycle; it is accepted on the next edge.
    task automatic issue(input logic ld, input logic st, input logic uns, input logic [1:0] w,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
        iReqVld = 1'b1; iMemEn = 1'b1; iLoad = ld; iStore = st; iUnsignedFlg = uns;
        iMemWidth = w; iAddr = a; iStoreDat = d; iRd = rd;
        tick();
        iReqVld = 1'b0; iMemEn = 1'b0; iLoad = 1'b0; iStore = 1'b0;
    endtask

    // Load with gnt in the first REQ cycle and rvld one cycle later.
    task automatic load_two_phase(input string tag, input logic uns, input logic [1:0] w,
                                  input logic [31:0] a, input logic [4:0] rd,
                                  input logic [31:0] rdat, input logic [31:0] exp_dat);
        issue(1'b1, 1'b0, uns, w, a, 32'h0, rd);
        check_val({tag, "_req"}, {31'd0, oMemReq}, 32'd1);
        check_val({tag, "_wr"}, {31'd0, oMemWr}, 32'd0);
        iMemGnt = 1'b1;
        tick();
        iMemGnt = 1'b0;
        check_val({tag, "_rsp_req"}, {31'd0, oMemReq}, 32'd0);
        check_val({tag, "_rsp_busy"}, {31'd0, oBusy}, 32'd1);
        iMemRvld = 1'b1; iMemRdat = rdat;
        tick();
        iMemRvld = 1'b0;
        check_val({tag, "_wbvld"}, {31'd0, oWbVld}, 32'd1);
        check_val({tag, "_wbrd"}, {27'd0, oWbRd}, {27'd0, rd});
        check_val({tag, "_wbdat"}, oWbDat, exp_dat);
        check_val({tag, "_done"}, {31'd0, oDone}, 32'd1);
        tick();
        check_val({tag, "_idle"}, {31'd0, oReqRdy}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; iReqVld = 1'b0; iMemEn = 1'b0; iLoad = 1'b0; iStore = 1'b0;
        iUnsignedFlg = 1'b0; iMemWidth = 2'b00; iStoreDat = 32'h0; iAddr = 32'h0;
        iRd = 5'd0; iMemGnt = 1'b0; iMemRvld = 1'b0; iMemRdat = 32'h0;
        #23;
        check_val("rst_req", {31'd0, oMemReq}, 32'd0);
        check_val("rst_rdy", {31'd0, oReqRdy}, 32'd1);
        check_val("rst_excaddr", oExcAddr, RST_PC);
        check_val("rst_done", {31'd0, oDone}, 32'd0);
        rst_n = 1'b1;
        tick();

        // iMemEn low: no action.
        iReqVld = 1'b1; iMemEn = 1'b0; iLoad = 1'b1; iMemWidth = 2'b10; iAddr = 32'h10;
        tick();
        iReqVld = 1'b0; iLoad = 1'b0;
        check_val("noen_busy", {31'd0, oBusy}, 32'd0);
        check_val("noen_req", {31'd0, oMemReq}, 32'd0);

        // Store byte at 0x1003, gnt in the second REQ cycle.
        issue(1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_1003, 32'h0000_00AB, 5'd0);
        check_val("stb_req", {31'd0, oMemReq}, 32'd1);
        check_val("stb_wr", {31'd0, oMemWr}, 32'd1);
        check_val("stb_addr", oMemAddr, 32'h0000_1000);
        check_val("stb_be", {28'd0, oMemBe}, 32'h8);
        check_val("stb_wdat", oMemWdat, 32'hABAB_ABAB);
        check_val("stb_rdy", {31'd0, oReqRdy}, 32'd0);
        tick();
        check_val("stb_req_hold", {31'd0, oMemReq}, 32'd1);
        check_val("stb_addr_hold", oMemAddr, 32'h0000_1000);
        iMemGnt = 1'b1;
        tick();
        iMemGnt = 1'b0;
        check_val("stb_done", {31'd0, oDone}, 32'd1);
        check_val("stb_wbvld", {31'd0, oWbVld}, 32'd0);
        check_val("stb_req_drop", {31'd0, oMemReq}, 32'd0);
        check_val("stb_exc", {31'd0, oExcVld}, 32'd0);
        tick();
        check_val("stb_done_pulse", {31'd0, oDone}, 32'd0);
        check_val("stb_idle", {31'd0, oReqRdy}, 32'd1);

        // Store half at 0x1006: upper lanes, data replicated.
        issue(1'b0, 1'b1, 1'b0, 2'b01, 32'h0000_1006, 32'h1234_BEEF, 5'd0);
        check_val("sth_be", {28'd0, oMemBe}, 32'hC);
        check_val("sth_wdat", oMemWdat, 32'hBEEF_BEEF);
        iMemGnt = 1'b1;
        tick();
        iMemGnt = 1'b0;
        check_val("sth_done", {31'd0, oDone}, 32'd1);
        tick();

        // Half loads at 0x2002, signed then unsigned.
        load_two_phase("ldh_s", 1'b0, 2'b01, 32'h0000_2002, 5'd5, 32'h8001_1234, 32'hFFFF_8001);
        load_two_phase("ldh_u", 1'b1, 2'b01, 32'h0000_2002, 5'd5, 32'h8001_1234, 32'h0000_8001);
        load_two_phase("ldb_u1", 1'b1, 2'b00, 32'h0000_2001, 5'd9, 32'h1234_5678, 32'h0000_0056);
        load_two_phase("ldw", 1'b1, 2'b10, 32'h0000_2004, 5'd31, 32'h8765_4321, 32'h8765_4321);

        // Misaligned word load at 0x3001.
        issue(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_3001, 32'h0, 5'd4);
        check_val("mis_exc", {31'd0, oExcVld}, 32'd1);
        check_val("mis_cause", {30'd0, oExcCause}, 32'd1);
        check_val("mis_addr", oExcAddr, 32'h0000_3001);
        check_val("mis_done", {31'd0, oDone}, 32'd1);
        check_val("mis_req", {31'd0, oMemReq}, 32'd0);
        check_val("mis_wbvld", {31'd0, oWbVld}, 32'd0);
        tick();
        check_val("mis_exc_pulse", {31'd0, oExcVld}, 32'd0);
        check_val("mis_req_after", {31'd0, oMemReq}, 32'd0);

        // Reserved width.
        issue(1'b0, 1'b1, 1'b0, 2'b11, 32'h0000_4000, 32'h0, 5'd0);
        check_val("rsv_exc", {31'd0, oExcVld}, 32'd1);
        check_val("rsv_cause", {30'd0, oExcCause}, 32'd2);
        check_val("rsv_req", {31'd0, oMemReq}, 32'd0);
        tick();

        // Byte load rd=0 with gnt and rvld in the same cycle.
        issue(1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0000, 32'h0, 5'd0);
        iMemGnt = 1'b1; iMemRvld = 1'b1; iMemRdat = 32'h0000_0080;
        tick();
        iMemGnt = 1'b0; iMemRvld = 1'b0;
        check_val("ldb0_done", {31'd0, oDone}, 32'd1);
        check_val("ldb0_wbvld", {31'd0, oWbVld}, 32'd0);
        tick();
        check_val("ldb0_rdy", {31'd0, oReqRdy}, 32'd1);

        // Same pattern with rd=7 checks sign extension of the byte.
        issue(1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0000, 32'h0, 5'd7);
        iMemGnt = 1'b1; iMemRvld = 1'b1; iMemRdat = 32'h0000_0080;
        tick();
        iMemGnt = 1'b0; iMemRvld = 1'b0;
        check_val("ldb7_wbvld", {31'd0, oWbVld}, 32'd1);
        check_val("ldb7_wbdat", oWbDat, 32'hFFFF_FF80);
        tick();

        // Timeout: gnt never arrives; four REQ cycles then exception.
        issue(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_5000, 32'h0, 5'd2);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("to_req%0d", i), {31'd0, oMemReq}, 32'd1);
            check_val($sformatf("to_noexc%0d", i), {31'd0, oExcVld}, 32'd0);
            tick();
        end
        check_val("to_exc", {31'd0, oExcVld}, 32'd1);
        check_val("to_cause", {30'd0, oExcCause}, 32'd3);
        check_val("to_addr", oExcAddr, 32'h0000_5000);
        check_val("to_req_drop", {31'd0, oMemReq}, 32'd0);
        check_val("to_done", {31'd0, oDone}, 32'd1);
        tick();
        iMemRvld = 1'b1; iMemRdat = 32'hFFFF_FFFF;
        tick();
        iMemRvld = 1'b0;
        check_val("to_late_wb", {31'd0, oWbVld}, 32'd0);
        check_val("to_late_busy", {31'd0, oBusy}, 32'd0);

        // Async reset in the middle of RSP.
        issue(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_6000, 32'h0, 5'd3);
        iMemGnt = 1'b1;
        tick();
        iMemGnt = 1'b0;
        check_val("ar_in_rsp", {31'd0, oBusy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("ar_busy", {31'd0, oBusy}, 32'd0);
        check_val("ar_addr", oMemAddr, 32'h0);
        check_val("ar_be", {28'd0, oMemBe}, 32'h0);
        check_val("ar_excaddr", oExcAddr, RST_PC);
        check_val("ar_cause", {30'd0, oExcCause}, 32'd0);
        check_val("ar_wbdat", oWbDat, 32'h0);
        tick();
        rst_n = 1'b1;
        iMemRvld = 1'b1; iMemGnt = 1'b1; iMemRdat = 32'h1111_2222;
        tick();
        iMemRvld = 1'b0; iMemGnt = 1'b0;
        check_val("ar_late_wb", {31'd0, oWbVld}, 32'd0);
        check_val("ar_late_done", {31'd0, oDone}, 32'd0);
        check_val("ar_late_rdy", {31'd0, oReqRdy}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
        $finish;
    end

endmodule
